// File: rtl/fizzbuzz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fizzbuzz_pkg
//  Description : Shared token kind, token record and flag classifier for the
//                fizzbuzz token stream.
//  Revision    : 1.0 - initial release
// ============================================================================
package fizzbuzz_pkg;

  // Token kinds emitted to the sink
  typedef enum logic [1:0] {
    NUM      = 2'd0,
    FIZZ     = 2'd1,
    BUZZ     = 2'd2,
    FIZZBUZZ = 2'd3
  } kind_t;

  // Widest index a token record can carry
  localparam int unsigned TOKEN_VAL_W = 16;

  // Token record: kind plus counter index
  typedef struct packed {
    kind_t                  kind;
    logic [TOKEN_VAL_W-1:0] value;
  } token_t;

  // Priority classification. fizzbuzz wins even when fizz/buzz disagree.
  function automatic kind_t classify(input logic i_fizz,
                                     input logic i_buzz,
                                     input logic i_fizzbuzz);
    kind_t k;
    k = NUM;
    if (i_fizzbuzz)  k = FIZZBUZZ;
    else if (i_fizz) k = FIZZ;
    else if (i_buzz) k = BUZZ;
    return k;
  endfunction

endpackage : fizzbuzz_pkg
`default_nettype wire

// File: rtl/fizzbuzz_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fizzbuzz_fifo
//  Description : Circular-buffer FIFO with wrap-bit pointers. The head entry
//                is presented combinationally and reads as zero when empty.
//                The caller guarantees no push while full without a pop and
//                no pop while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module fizzbuzz_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;

  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];

  // Equal pointers mean empty; same address with opposite wrap bits means full
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = o_empty ? '0 : r_mem[w_rd_addr];

  // Pointer advance; both may move in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty output is forced to zero
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_addr] <= i_wr_data;
  end

endmodule : fizzbuzz_fifo
`default_nettype wire

// File: rtl/fizzbuzz_token_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fizzbuzz_token_stream
//  Description : Classifies fizz/buzz/fizzbuzz flags into tokens tagged with
//                the counter index and buffers them for a valid/ready sink.
//                Tokens offered while the buffer is full (and not popping)
//                are dropped and flagged through the sticky overflow output.
//                Optional build macro FIZZBUZZ_DROP_CNT_EN enables a
//                saturating 16-bit dropped-token counter on drop_cnt;
//                without it drop_cnt is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fizzbuzz_token_stream
  import fizzbuzz_pkg::*;
#(
  parameter  int unsigned MAX_CYCLES = 100,
  parameter  int unsigned DEPTH      = 4,
  localparam int unsigned VAL_W      = $clog2(MAX_CYCLES),
  localparam int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic             fizz,
  input  logic             buzz,
  input  logic             fizzbuzz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [VAL_W-1:0] out_value,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned TOK_W = 2 + VAL_W;
  localparam logic [VAL_W-1:0] c_IDX_LAST = VAL_W'(MAX_CYCLES - 1);

  logic [VAL_W-1:0] r_idx;
  logic             r_overflow;
  kind_t            w_kind;
  logic [TOK_W-1:0] w_wr_data;
  logic [TOK_W-1:0] w_rd_data;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_kind    = classify(fizz, buzz, fizzbuzz);
  assign w_wr_data = {w_kind, r_idx};

  // A full buffer still accepts a token when the head leaves in the same cycle
  assign w_pop  = ~w_empty & out_ready;
  assign w_push = in_valid & (~w_full | w_pop);
  assign w_drop = in_valid & w_full & ~w_pop;

  // Index follows every offered token, dropped or not, so tags stay aligned
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx <= '0;
    end else if (!in_valid) begin
      r_idx <= '0;
    end else if (r_idx == c_IDX_LAST) begin
      r_idx <= '0;
    end else begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Sticky overflow, cleared only by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef FIZZBUZZ_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating count of discarded tokens
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'd0;
`endif

  fizzbuzz_fifo #(
    .WIDTH (TOK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (w_wr_data),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (level)
  );

  assign out_valid = ~w_empty;
  assign out_kind  = w_rd_data[TOK_W-1 -: 2];
  assign out_value = w_rd_data[VAL_W-1:0];
  assign overflow  = r_overflow;

endmodule : fizzbuzz_token_stream
`default_nettype wire
